// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencer.
// Used by aes_round_ctrl and aes_rctrl_stats.
package aes_pkg;

    localparam int RK_IDX_W = 4;
    localparam int NR_MAX   = 14;
    localparam int NR_128   = 10;
    localparam int NR_192   = 12;
    localparam int NR_256   = 14;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } aes_rctrl_state_t;

endpackage

// File: rtl/aes_rctrl_stats.sv
// Block completion and key-stall counters for the round sequencer.
// Only instantiated when AES_RCTRL_STATS_EN is defined.
module aes_rctrl_stats
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        done,
    output logic [31:0] blk_count,
    output logic [15:0] stall_count
);

    logic [31:0] blk_q;
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q   <= '0;
            stall_q <= '0;
        end else begin
            if (done)
                blk_q <= blk_q + 32'd1;
            // saturate so long key-RAM outages never read as few stalls
            if (stall && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
        end
    end

    assign blk_count   = rst ? '0 : blk_q;
    assign stall_count = rst ? '0 : stall_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: load, NR rounds, present result.
// Optional statistics counters are enabled by AES_RCTRL_STATS_EN.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                key_start,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic                rk_valid,
    output logic                dp_load,
    output logic                dp_round_en,
    output logic                dp_final,
    output logic                out_valid,
    input  logic                out_ready
`ifdef AES_RCTRL_STATS_EN
    ,
    output logic [31:0]         blk_count,
    output logic [15:0]         stall_count
`endif
);

    generate
        if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_bad_nr
            $error("aes_round_ctrl: NR must be 10, 12 or 14");
        end
    endgenerate

    aes_rctrl_state_t    state_q, state_d;
    logic [RK_IDX_W-1:0] ridx_q, ridx_d;

    always_comb begin
        state_d = state_q;
        ridx_d  = ridx_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_LOAD;
                    ridx_d  = '0;
                end
            end
            S_LOAD: begin
                if (rk_valid) begin
                    state_d = S_ROUND;
                    ridx_d  = RK_IDX_W'(1);
                end
            end
            S_ROUND: begin
                if (rk_valid) begin
                    ridx_d = ridx_q + RK_IDX_W'(1);
                    if (ridx_q == RK_IDX_W'(NR - 1))
                        state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                if (rk_valid)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    ridx_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ridx_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ridx_q  <= '0;
        end else begin
            state_q <= state_d;
            ridx_q  <= ridx_d;
        end
    end

    // every output is forced low while rst is held
    assign in_ready    = !rst && state_q == S_IDLE;
    assign key_start   = in_ready && in_valid;
    assign rk_idx      = rst ? '0 : ridx_q;
    assign dp_load     = !rst && rk_valid && state_q == S_LOAD;
    assign dp_round_en = !rst && rk_valid &&
                         (state_q == S_ROUND || state_q == S_FINAL);
    assign dp_final    = !rst && rk_valid && state_q == S_FINAL;
    assign out_valid   = !rst && state_q == S_DONE;

`ifdef AES_RCTRL_STATS_EN
    logic busy;
    assign busy = state_q == S_LOAD || state_q == S_ROUND ||
                  state_q == S_FINAL;

    aes_rctrl_stats u_stats (
        .clk         (clk),
        .rst         (rst),
        .stall       (busy && !rk_valid),
        .done        (out_valid && out_ready),
        .blk_count   (blk_count),
        .stall_count (stall_count)
    );
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl (NR=10 and NR=14 instances).
module tb_aes_round_ctrl;

    logic       clk;
    int         cyc;
    int         checks;
    int         failures;

    logic       rst_a[2];
    logic       in_valid_a[2];
    logic       in_ready_a[2];
    logic       key_start_a[2];
    logic [3:0] rk_idx_a[2];
    logic       rk_valid_a[2];
    logic       dp_load_a[2];
    logic       dp_round_en_a[2];
    logic       dp_final_a[2];
    logic       out_valid_a[2];
    logic       out_ready_a[2];
`ifdef AES_RCTRL_STATS_EN
    logic [31:0] blk_a[2];
    logic [15:0] stc_a[2];
`endif

    aes_round_ctrl #(.NR(10)) dut0 (
        .clk         (clk),
        .rst         (rst_a[0]),
        .in_valid    (in_valid_a[0]),
        .in_ready    (in_ready_a[0]),
        .key_start   (key_start_a[0]),
        .rk_idx      (rk_idx_a[0]),
        .rk_valid    (rk_valid_a[0]),
        .dp_load     (dp_load_a[0]),
        .dp_round_en (dp_round_en_a[0]),
        .dp_final    (dp_final_a[0]),
        .out_valid   (out_valid_a[0]),
        .out_ready   (out_ready_a[0])
`ifdef AES_RCTRL_STATS_EN
        ,
        .blk_count   (blk_a[0]),
        .stall_count (stc_a[0])
`endif
    );

    aes_round_ctrl #(.NR(14)) dut1 (
        .clk         (clk),
        .rst         (rst_a[1]),
        .in_valid    (in_valid_a[1]),
        .in_ready    (in_ready_a[1]),
        .key_start   (key_start_a[1]),
        .rk_idx      (rk_idx_a[1]),
        .rk_valid    (rk_valid_a[1]),
        .dp_load     (dp_load_a[1]),
        .dp_round_en (dp_round_en_a[1]),
        .dp_final    (dp_final_a[1]),
        .out_valid   (out_valid_a[1]),
        .out_ready   (out_ready_a[1])
`ifdef AES_RCTRL_STATS_EN
        ,
        .blk_count   (blk_a[1]),
        .stall_count (stc_a[1])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h",
                     name, k, cyc, act, exp);
        end
    endtask

    // Transaction-level model: a block is either waiting for keys
    // (busy, with 'step' keys consumed so far) or finished (done).
    bit          m_busy[2];
    bit          m_done[2];
    int          m_step[2];
    logic [31:0] m_blk[2];
    logic [15:0] m_stall[2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_busy[k]  = 0;
            m_done[k]  = 0;
            m_step[k]  = 0;
            m_blk[k]   = '0;
            m_stall[k] = '0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int   nr;
            logic idle, e_ir, e_ks, e_ld, e_re, e_fn, e_ov;
            int   e_idx;
            nr   = (k == 0) ? 10 : 14;
            idle = !m_busy[k] && !m_done[k];
            if (rst_a[k]) begin
                e_ir = 0; e_ks = 0; e_ld = 0; e_re = 0;
                e_fn = 0; e_ov = 0; e_idx = 0;
            end else begin
                e_ir  = idle;
                e_ks  = idle && in_valid_a[k];
                e_ld  = m_busy[k] && rk_valid_a[k] && m_step[k] == 0;
                e_re  = m_busy[k] && rk_valid_a[k] && m_step[k] > 0;
                e_fn  = m_busy[k] && rk_valid_a[k] && m_step[k] == nr;
                e_ov  = m_done[k];
                e_idx = m_busy[k] ? m_step[k] : (m_done[k] ? nr : 0);
            end
            chk("in_ready", k, 32'(in_ready_a[k]), 32'(e_ir));
            chk("key_start", k, 32'(key_start_a[k]), 32'(e_ks));
            chk("dp_load", k, 32'(dp_load_a[k]), 32'(e_ld));
            chk("dp_round_en", k, 32'(dp_round_en_a[k]), 32'(e_re));
            chk("dp_final", k, 32'(dp_final_a[k]), 32'(e_fn));
            chk("out_valid", k, 32'(out_valid_a[k]), 32'(e_ov));
            chk("rk_idx", k, 32'(rk_idx_a[k]), 32'(e_idx));
`ifdef AES_RCTRL_STATS_EN
            chk("blk_count", k, blk_a[k], rst_a[k] ? 32'd0 : m_blk[k]);
            chk("stall_count", k, 32'(stc_a[k]),
                rst_a[k] ? 32'd0 : 32'(m_stall[k]));
`endif
            if (rst_a[k]) begin
                m_busy[k]  = 0;
                m_done[k]  = 0;
                m_step[k]  = 0;
                m_blk[k]   = '0;
                m_stall[k] = '0;
            end else if (idle) begin
                if (in_valid_a[k]) begin
                    m_busy[k] = 1;
                    m_step[k] = 0;
                end
            end else if (m_busy[k]) begin
                if (!rk_valid_a[k]) begin
                    if (m_stall[k] != 16'hFFFF)
                        m_stall[k] = m_stall[k] + 16'd1;
                end else if (m_step[k] == nr) begin
                    m_busy[k] = 0;
                    m_done[k] = 1;
                end else begin
                    m_step[k] = m_step[k] + 1;
                end
            end else if (out_ready_a[k]) begin
                m_done[k] = 0;
                m_blk[k]  = m_blk[k] + 32'd1;
            end
        end
    end

    // Event log for the hand-computed timing checks.
    int ks0[$], ld0[$], re0[$], fin0[$], fidx0[$], ov0[$];
    int ks1[$], fidx1[$];

    always @(negedge clk) begin
        if (key_start_a[0])  ks0.push_back(cyc);
        if (dp_load_a[0])    ld0.push_back(cyc);
        if (dp_round_en_a[0] && !dp_final_a[0]) re0.push_back(cyc);
        if (dp_final_a[0]) begin
            fin0.push_back(cyc);
            fidx0.push_back(int'(rk_idx_a[0]));
        end
        if (out_valid_a[0])  ov0.push_back(cyc);
        if (key_start_a[1])  ks1.push_back(cyc);
        if (dp_final_a[1])   fidx1.push_back(int'(rk_idx_a[1]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        ks0.delete(); ld0.delete(); re0.delete();
        fin0.delete(); fidx0.delete(); ov0.delete();
        ks1.delete(); fidx1.delete();
    endtask

    function automatic int first(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    int t0;

    initial begin
        checks   = 0;
        failures = 0;
        for (int k = 0; k < 2; k++) begin
            rst_a[k]       = 1'b1;
            in_valid_a[k]  = 1'b0;
            rk_valid_a[k]  = 1'b0;
            out_ready_a[k] = 1'b0;
        end
        tick();
        tick();
        @(negedge clk);
        chk("rst_in_ready", 0, 32'(in_ready_a[0]), 32'd0);
        tick();
        for (int k = 0; k < 2; k++) begin
            rst_a[k]       = 1'b0;
            rk_valid_a[k]  = 1'b1;
            out_ready_a[k] = 1'b1;
        end
        tick();

        // nominal NR=10 block
        clear_log();
        t0 = cyc;
        in_valid_a[0] = 1'b1;
        tick();
        in_valid_a[0] = 1'b0;
        repeat (14) tick();
        chk("ks_cnt", 0, 32'(ks0.size()), 32'd1);
        chk("ks_cyc", 0, 32'(first(ks0)), 32'(t0));
        chk("load_cyc", 0, 32'(first(ld0)), 32'(t0 + 1));
        chk("round_cnt", 0, 32'(re0.size()), 32'd9);
        chk("round_first", 0, 32'(first(re0)), 32'(t0 + 2));
        chk("final_cyc", 0, 32'(first(fin0)), 32'(t0 + 11));
        chk("final_idx", 0, 32'(first(fidx0)), 32'd10);
        chk("ov_cnt", 0, 32'(ov0.size()), 32'd1);
        chk("ov_cyc", 0, 32'(first(ov0)), 32'(t0 + 12));

        // three-cycle key stall at rk_idx 4
        clear_log();
        t0 = cyc;
        in_valid_a[0] = 1'b1;
        tick();
        in_valid_a[0] = 1'b0;
        repeat (4) tick();
        rk_valid_a[0] = 1'b0;
        @(negedge clk);
        chk("stall_idx", 0, 32'(rk_idx_a[0]), 32'd4);
        chk("stall_strobe", 0, 32'(dp_round_en_a[0]), 32'd0);
        repeat (3) tick();
        rk_valid_a[0] = 1'b1;
        repeat (10) tick();
        chk("stall_ov_cyc", 0, 32'(first(ov0)), 32'(t0 + 15));
`ifdef AES_RCTRL_STATS_EN
        chk("stall_total", 0, 32'(stc_a[0]), 32'd3);
`endif

        // output backpressure with ignored in_valid pulses
        clear_log();
        out_ready_a[0] = 1'b0;
        t0 = cyc;
        in_valid_a[0] = 1'b1;
        tick();
        in_valid_a[0] = 1'b0;
        repeat (11) tick();
        for (int i = 0; i < 5; i++) begin
            in_valid_a[0] = (i % 2 == 0);
            @(negedge clk);
            chk("bp_ov", 0, 32'(out_valid_a[0]), 32'd1);
            chk("bp_ir", 0, 32'(in_ready_a[0]), 32'd0);
            tick();
        end
        in_valid_a[0]  = 1'b0;
        out_ready_a[0] = 1'b1;
        tick();
        chk("bp_ov_cnt", 0, 32'(ov0.size()), 32'd6);
        chk("bp_ks_cnt", 0, 32'(ks0.size()), 32'd1);

        // reset in the middle of a block
        clear_log();
        in_valid_a[0] = 1'b1;
        tick();
        in_valid_a[0] = 1'b0;
        repeat (5) tick();
        rst_a[0] = 1'b1;
        @(negedge clk);
        chk("mid_rst_ir", 0, 32'(in_ready_a[0]), 32'd0);
        chk("mid_rst_idx", 0, 32'(rk_idx_a[0]), 32'd0);
        chk("mid_rst_re", 0, 32'(dp_round_en_a[0]), 32'd0);
        tick();
        rst_a[0] = 1'b0;
        @(negedge clk);
        chk("post_rst_ir", 0, 32'(in_ready_a[0]), 32'd1);
        repeat (20) tick();
        chk("abandon_ov", 0, 32'(ov0.size()), 32'd0);
        clear_log();
        t0 = cyc;
        in_valid_a[0] = 1'b1;
        tick();
        in_valid_a[0] = 1'b0;
        repeat (13) tick();
        chk("fresh_ov_cyc", 0, 32'(first(ov0)), 32'(t0 + 12));

        // NR=14 back to back
        clear_log();
        in_valid_a[1] = 1'b1;
        repeat (68) tick();
        in_valid_a[1] = 1'b0;
        chk("b2b_ks_cnt", 1, 32'(ks1.size()), 32'd4);
        for (int i = 1; i < 4; i++)
            chk("b2b_period", 1, 32'(ks1[i] - ks1[i-1]), 32'd17);
        chk("b2b_fin_cnt", 1, 32'(fidx1.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("b2b_fin_idx", 1, 32'(fidx1[i]), 32'd14);
`ifdef AES_RCTRL_STATS_EN
        @(negedge clk);
        chk("b2b_blk", 1, blk_a[1], 32'd4);
        tick();
        force dut1.u_stats.blk_q = 32'hFFFF_FFFF;
        #1;
        release dut1.u_stats.blk_q;
        m_blk[1] = 32'hFFFF_FFFF;
        in_valid_a[1] = 1'b1;
        tick();
        in_valid_a[1] = 1'b0;
        repeat (18) tick();
        chk("blk_wrap", 1, blk_a[1], 32'd0);
`endif

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES round sequencer: accepts one plaintext block per transaction, steps the shared single-round datapath through the initial AddRoundKey, rounds 1..NR-1 and the final round, then presents the result. It sits between the block input interface, the round-key source (key expander or key RAM) and the round datapath. The round datapath carries the state register and the round-key bus that on-chip monitors tap. This block holds no data, only sequencing.

## Interface
- NR, 10, number of AES rounds; legal values 10, 12, 14.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset rst, synchronous, active-high.
- in_valid  in  1  plaintext block available at datapath input.
- in_ready  out  1  controller can accept a block.
- key_start  out  1  one-cycle pulse on acceptance; key source restarts at index 0.
- rk_idx  out  4  round-key index currently required.
- rk_valid  in  1  round key for rk_idx is present on the key bus this cycle.
- dp_load  out  1  datapath captures plaintext XOR rk0.
- dp_round_en  out  1  datapath performs one round with the current key.
- dp_final  out  1  qualifies dp_round_en; omit MixColumns.
- out_valid  out  1  ciphertext stable at datapath output.
- out_ready  in  1  downstream consumes ciphertext.

## Operation
- States: IDLE, LOAD, ROUND, FINAL, DONE. Registered state and round counter `ridx` (4 bit); rk_idx = ridx.
- IDLE: in_ready=1. On in_valid&in_ready: key_start=1, ridx<=0, go LOAD.
- LOAD: dp_load=rk_valid. On rk_valid: ridx<=1, go ROUND.
- ROUND: dp_round_en=rk_valid. On rk_valid: ridx<=ridx+1; if ridx==NR-1 go FINAL.
- FINAL: ridx==NR; dp_round_en=dp_final=rk_valid. On rk_valid go DONE.
- DONE: out_valid=1 until out_ready, then go IDLE, ridx<=0.
- rk_valid=0 in LOAD/ROUND/FINAL is a stall. State and ridx are held, and all dp_* strobes are 0.
- dp_load, dp_round_en, dp_final and key_start are combinational from state, in_valid and rk_valid. At most one of dp_load and dp_round_en is high in any cycle.
- in_ready=0 outside IDLE. in_valid there is ignored and no block is queued.
- out_valid, once high, stays high until out_ready. No new block is accepted in the same cycle as completion.
- Reset: state<=IDLE, ridx<=0. While rst=1, all outputs are 0, including in_ready. Reset mid-block abandons the block, and no out_valid follows it.

## Timing
- Acceptance at cycle T with rk_valid held high: LOAD at T+1, ROUND at T+2..T+NR, FINAL at T+NR+1, out_valid first high at T+NR+2.
- For NR=10, out_valid is first high at T+12.
- Each stall cycle adds exactly one cycle to latency.
- Minimum block period is NR+3 cycles: DONE with out_ready at cycle D, IDLE at D+1, next acceptance at D+1.

## Configuration
- AES_RCTRL_STATS_EN defined: adds output blk_count (32 bit) and output stall_count (16 bit). Both reset to 0.
  - blk_count increments on out_valid&out_ready and wraps at 2^32.
  - stall_count increments on each stall cycle and saturates at 0xFFFF.
- AES_RCTRL_STATS_EN undefined: both ports and their counters are absent. Sequencing behaviour is identical.

## Structure
- Shared package aes_pkg holds:
  - the state enum aes_rctrl_state_t;
  - RK_IDX_W=4 and NR_MAX=14;
  - constants NR_128=10, NR_192=12 and NR_256=14.
- Elaboration check rejects NR outside {10, 12, 14}.
- One sub-module, aes_rctrl_stats, holds both counters and is instantiated only under AES_RCTRL_STATS_EN.

## Test plan
- NR=10, rk_valid=1, in_valid pulse at T, out_ready=1:
  - key_start at T, dp_load at T+1;
  - dp_round_en with rk_idx 1..9 at T+2..T+10;
  - dp_final with rk_idx=10 at T+11;
  - out_valid at T+12 only, in_ready back at T+13.
- Stalls: rk_valid=0 for 3 cycles in ROUND at rk_idx=4 → rk_idx holds 4, no strobes during the stall, out_valid at T+15. With STATS, stall_count=3.
- Backpressure: out_ready=0 for 5 cycles after completion → out_valid held 5+ cycles, in_ready=0 throughout, in_valid pulses ignored.
- Reset mid-block: rst at T+6 for one cycle → all outputs 0 during reset, IDLE with in_ready=1 next cycle, no out_valid. Then a fresh block completes in NR+2 cycles.
- NR=14 back-to-back, in_valid=1 and out_ready=1 continuously:
  - acceptances every 17 cycles;
  - final strobe at rk_idx=14;
  - with STATS, blk_count=4 after 4 blocks;
  - blk_count preloaded via force to 0xFFFFFFFF wraps to 0.
